// File: rtl/muldiv_pkg.sv
// Shared constants, state encoding and operand-signedness helpers for the
// sequential RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int XLEN  = 32;
    localparam int ITER  = 32;
    localparam int CNT_W = $clog2(ITER);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Divide-class ops are exactly those with funct3[2] set.
    function automatic logic is_div(input logic [2:0] op);
        return op >= OP_DIV;
    endfunction

    function automatic logic a_signed(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic b_signed(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_fsm.sv
// Control sequencer: state register, iteration counter and the
// load/step/fix/done strobes that drive the muldiv datapath.
module muldiv_fsm
    import muldiv_pkg::*;
(
    input  logic clk,
    input  logic clrn,
    input  logic start,
    input  logic flush,
    input  logic skip,
    output logic busy,
    output logic load,
    output logic step,
    output logic fix,
    output logic done
);

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   count;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            count <= '0;
        end else if (load) begin
            count <= CNT_W'(ITER - 1);
        end else if (step && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    // flush beats start, so a killed request is never accepted.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        step       = 1'b0;
        fix        = 1'b0;
        case (state)
            IDLE, DONE: begin
                next_state = IDLE;
                if (start && !flush) begin
                    load       = 1'b1;
                    next_state = skip ? FIX : CALC;
                end
            end
            CALC: begin
                if (flush) begin
                    next_state = IDLE;
                end else begin
                    step = 1'b1;
                    if (count == '0) begin
                        next_state = FIX;
                    end
                end
            end
            FIX: begin
                if (flush) begin
                    next_state = IDLE;
                end else begin
                    fix        = 1'b1;
                    next_state = DONE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign busy = (state == CALC) || (state == FIX);
    assign done = (state == DONE);

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and restoring
// divider on operand magnitudes, with a sign fix-up before the result strobe.
module muldiv_seq
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            clrn,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            busy,
    output logic            valid,
    output logic [XLEN-1:0] r,
    output logic [4:0]      rd_out
);

    logic            load, step, fix, skip;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;

    logic [XLEN-1:0] hi, lo, md, a_keep;
    logic [2:0]      op_q;
    logic [4:0]      rd_q;
    logic            neg_res, neg_rem, div_zero;

    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_result;

    muldiv_fsm u_fsm (
        .clk   (clk),
        .clrn  (clrn),
        .start (start),
        .flush (flush),
        .skip  (skip),
        .busy  (busy),
        .load  (load),
        .step  (step),
        .fix   (fix),
        .done  (valid)
    );

    assign a_neg = a_signed(op) && a[XLEN-1];
    assign b_neg = b_signed(op) && b[XLEN-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;
    assign skip  = is_div(op) && (b == '0);

    // hi:lo is the product for multiplies and remainder:quotient for divides.
    assign mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, md} : '0);
    assign div_shift = {hi, lo[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, md};

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            hi       <= '0;
            lo       <= '0;
            md       <= '0;
            a_keep   <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
        end else if (load) begin
            hi       <= '0;
            lo       <= is_div(op) ? a_mag : b_mag;
            md       <= is_div(op) ? b_mag : a_mag;
            a_keep   <= a;
            op_q     <= op;
            rd_q     <= rd_in;
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            div_zero <= skip;
        end else if (step) begin
            if (is_div(op_q)) begin
                if (!div_diff[XLEN]) begin
                    hi <= div_diff[XLEN-1:0];
                    lo <= {lo[XLEN-2:0], 1'b1};
                end else begin
                    hi <= div_shift[XLEN-1:0];
                    lo <= {lo[XLEN-2:0], 1'b0};
                end
            end else begin
                hi <= mul_sum[XLEN:1];
                lo <= {mul_sum[0], lo[XLEN-1:1]};
            end
        end
    end

    assign prod     = {hi, lo};
    assign prod_fix = neg_res ? -prod : prod;
    assign quo_fix  = neg_res ? -lo : lo;
    assign rem_fix  = neg_rem ? -hi : hi;

    always_comb begin
        fix_result = '0;
        case (op_q)
            OP_MUL:                        fix_result = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fix_result = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               fix_result = div_zero ? '1 : quo_fix;
            default:                       fix_result = div_zero ? a_keep : rem_fix;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r      <= '0;
            rd_out <= '0;
        end else if (fix) begin
            r      <= fix_result;
            rd_out <= rd_q;
        end
    end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle sequencer for the RV32M multiply/divide operations in the EX stage.
- Runs an iterative shift-add multiplier and a restoring divider over 32 iterations, then applies a sign fix-up.
- Raises busy so the pipeline controller can stall; returns the result with a one-cycle valid pulse plus the destination-register tag.
- Cuts the combinational divide/multiply critical path out of the single-cycle ALU.

Parameters:
XLEN, 32, operand/result width; only 32 is supported
ITER, 32, iteration count, must equal XLEN

Ports:
clk  input  1  clock, rising edge
clrn  input  1  asynchronous active-low reset
start  input  1  request; accepted only in IDLE or DONE
op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
a  input  32  rs1 operand, sampled on accept
b  input  32  rs2 operand, sampled on accept
rd_in  input  5  destination tag, sampled on accept
flush  input  1  abort the in-flight operation (branch/exception kill)
busy  output  1  high in CALC and FIX
valid  output  1  one-cycle result strobe
r  output  32  result; held until the next accepted start
rd_out  output  5  tag belonging to r

Behaviour:
- Clock and reset: one clock, clk; reset clrn is asynchronous, active-low. While clrn=0: state=IDLE, busy=0, valid=0, r=0, rd_out=0, counter=0. Reset mid-operation discards the operation with no valid.
- States: IDLE, CALC, FIX, DONE. busy=(CALC|FIX); valid=(state==DONE).
- Accept: start=1 in IDLE or DONE at cycle t. Latch op, rd_in, operand magnitudes and the result sign; counter=ITER-1.
- Operand signedness: a is signed for MULH, MULHSU, DIV, REM; b is signed for MULH, DIV, REM. MUL takes the low word, which is sign-agnostic.
- Divide by zero (op[2]=1, b=0): skip CALC and go to FIX, so valid is at t+2.
- Normal path: CALC lasts t+1..t+32, one iteration per cycle, counter decrements and leaves CALC at 0. FIX at t+33, DONE/valid at t+34.
- Multiply: 64-bit shift-add on the magnitudes. In FIX, negate the 64-bit product if the signs differ. MUL returns bits[31:0]; the MULH variants return [63:32].
- Divide: restoring, one quotient bit per cycle on the magnitudes.
  - In FIX, negate the quotient if the signed operand signs differ.
  - The remainder takes the dividend's sign (signed ops only).
- Divide-by-zero results: DIV/DIVU give 0xFFFFFFFF; REM/REMU give a.
- Signed overflow 0x80000000 / 0xFFFFFFFF falls out of the magnitude path: quotient 0x80000000, remainder 0. No special state.
- DONE: valid=1 for exactly one cycle, then go to IDLE unless start=1, which is accepted the same cycle (back-to-back ops every 34 cycles).
- start while busy: ignored. There is no queue, and the requester must hold start until busy falls.
- flush: in CALC or FIX, go to IDLE next cycle, busy=0, no valid; r and rd_out are unchanged. In DONE, valid still pulses that cycle and the stage kill is the pipeline's job. If flush and start arrive together in IDLE/DONE, flush wins and nothing is accepted.
- r and rd_out update only on the FIX→DONE edge.

Decomposition:
- Package muldiv_pkg:
  - XLEN.
  - funct3 localparams OP_MUL..OP_REMU.
  - State encoding: IDLE=2'd0, CALC=2'd1, FIX=2'd2, DONE=2'd3.
  - Helpers is_div(op) = op[2] and a_signed(op)/b_signed(op).
- One sub-module, muldiv_fsm, holds the state register, iteration counter, busy/valid and accept/flush decode. It emits load, step, fix and done strobes. The datapath registers (accumulator, multiplicand/divisor, sign flags) stay in muldiv_seq.

Test Plan:
- MUL a=7, b=0xFFFFFFFD, accept at t → busy=1 during t+1..t+33; r=0xFFFFFFEB, valid=1 only at t+34.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULH same → 0x00000000; MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFF; rd_out matches each rd_in.
- DIV 0xFFFFFFF9/2 → 0xFFFFFFFD; REM same → 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 → 0x7FFFFFFC; REMU → 0x00000001.
- DIV 5/0 → 0xFFFFFFFF, valid at t+2; REMU 5/0 → 0x00000005; DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0, both at t+34.
- flush at t+10 → busy=0 at t+11, no valid, r unchanged. A start at t+11 is accepted, and its valid comes at t+45.
- start pulsed at t+5 while busy → ignored, single valid at t+34. clrn=0 at t+20 → busy/valid/r/rd_out=0 immediately, no valid after release.
